mag_comparator: RTL and testbench

Registered N-bit magnitude comparator producing one-hot greater/equal/lesser flags for operands A and B. It supports unsigned or two's-complement comparison, selected per sample. A valid qualifier accompanies each sample. Used as a leaf datapath block wherever a registered three-way compare result is needed.

---
 rtl/cmp_pkg.sv | 29 ++
 rtl/mag_compare_core.sv | 54 +++++
 rtl/mag_comparator.sv | 106 ++++++++++
 tb/tb_mag_comparator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the magnitude comparator.
//
// cmp_result_e : three-way compare outcome carried through the pipeline.
// cmp_onehot   : expands a compare outcome into the {gt, eq, lt} flag triple.
// PIPE_STAGES_MAX : deepest pipeline the comparator supports.
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_LT = 2'b00,
        CMP_EQ = 2'b01,
        CMP_GT = 2'b10
    } cmp_result_e;

    localparam int PIPE_STAGES_MAX = 3;

    // Returns {gt, eq, lt}. The unused encoding maps to all-zero so a corrupted
    // result can never show up as a legal one-hot flag.
    function automatic logic [2:0] cmp_onehot(cmp_result_e res);
        logic [2:0] flags;
        unique case (res)
            CMP_GT:  flags = 3'b100;
            CMP_EQ:  flags = 3'b010;
            CMP_LT:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/mag_compare_core.sv
// Combinational N-bit magnitude compare.
//
// Ports:
//   signed_mode : 0 = unsigned compare, 1 = two's-complement compare
//   A, B        : operands, WIDTH bits
//   result      : CMP_GT / CMP_EQ / CMP_LT for A versus B
//
// Walks the operands MSB first; the first differing bit decides. In signed
// mode the MSB carries negative weight, so a differing sign bit decides the
// opposite way (the operand with the sign bit clear is the larger one).
module mag_compare_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output cmp_result_e      result
);

    logic gt;
    logic lt;
    logic decided;

    always_comb begin
        gt      = 1'b0;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!decided && (A[i] != B[i])) begin
                decided = 1'b1;
                // Sign bit swap: with A's sign set and B's clear, A is smaller.
                if ((i == WIDTH - 1) && signed_mode) begin
                    gt = B[i];
                end else begin
                    gt = A[i];
                end
                lt = ~gt;
            end
        end
    end

    always_comb begin
        if (gt) begin
            result = CMP_GT;
        end else if (lt) begin
            result = CMP_LT;
        end else begin
            result = CMP_EQ;
        end
    end

endmodule

// File: rtl/mag_comparator.sv
// Registered N-bit magnitude comparator with one-hot greater/equal/lesser flags.
//
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid    : A, B and signed_mode are sampled this cycle
//   signed_mode : 0 = unsigned, 1 = two's-complement compare
//   A, B        : operands, WIDTH bits
//   out_valid   : flags below belong to a sampled input
//   A_greater_B, A_equal_B, A_lesser_B : one-hot compare result
//
// Structure: the core compares the live inputs; the edge that samples them
// is the first of PIPE_STAGES registers. Stages 1..PIPE_STAGES-1 form a
// result/valid shift chain and the last register is the output hold register,
// which only reloads its flags when a valid result arrives. A result is thus
// visible after edge k + PIPE_STAGES - 1 for a sample taken at edge k.
module mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             A_greater_B,
    output logic             A_equal_B,
    output logic             A_lesser_B
);

    // Elaboration-time parameter checks.
    if (WIDTH < 1) begin : gen_bad_width
        $error("mag_comparator: WIDTH must be >= 1");
    end
    if ((PIPE_STAGES < 1) || (PIPE_STAGES > PIPE_STAGES_MAX)) begin : gen_bad_stages
        $error("mag_comparator: PIPE_STAGES must be in 1..PIPE_STAGES_MAX");
    end

    cmp_result_e core_res;
    cmp_result_e feed_res;
    logic        feed_vld;

    mag_compare_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .signed_mode(signed_mode),
        .A          (A),
        .B          (B),
        .result     (core_res)
    );

    if (PIPE_STAGES > 1) begin : gen_chain
        localparam int ChainLen = PIPE_STAGES - 1;

        cmp_result_e            res_q [ChainLen];
        logic [ChainLen-1:0]    vld_q;

        // Result registers load only on a valid slot, so operands that are
        // unknown during an idle cycle never enter the chain.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                for (int i = 0; i < ChainLen; i++) begin
                    res_q[i] <= CMP_EQ;
                end
            end else begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    res_q[0] <= core_res;
                end
                for (int i = 1; i < ChainLen; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        res_q[i] <= res_q[i-1];
                    end
                end
            end
        end

        assign feed_res = res_q[ChainLen-1];
        assign feed_vld = vld_q[ChainLen-1];
    end else begin : gen_no_chain
        assign feed_res = core_res;
        assign feed_vld = in_valid;
    end

    // Output hold register: flags keep their last valid value across idle
    // slots and are all-zero from reset until the first valid result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            A_greater_B <= 1'b0;
            A_equal_B   <= 1'b0;
            A_lesser_B  <= 1'b0;
        end else begin
            out_valid <= feed_vld;
            if (feed_vld) begin
                {A_greater_B, A_equal_B, A_lesser_B} <= cmp_onehot(feed_res);
            end
        end
    end

endmodule

// File: tb/tb_mag_comparator.sv
// Self-checking bench for mag_comparator: instances with PIPE_STAGES=1 and 3
// share one stimulus stream and are checked each cycle against a history
// based reference model; a WIDTH=1 instance covers the single-bit boundary.
module tb_mag_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       signed_mode;
    logic [3:0] A;
    logic [3:0] B;

    logic ov1, g1, e1, l1;
    logic ov3, g3, e3, l3;
    logic ovw, gw, ew, lw;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mag_comparator #(.WIDTH(4), .PIPE_STAGES(1)) u_p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
        .A(A), .B(B), .out_valid(ov1),
        .A_greater_B(g1), .A_equal_B(e1), .A_lesser_B(l1)
    );

    mag_comparator #(.WIDTH(4), .PIPE_STAGES(3)) u_p3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
        .A(A), .B(B), .out_valid(ov3),
        .A_greater_B(g3), .A_equal_B(e3), .A_lesser_B(l3)
    );

    mag_comparator #(.WIDTH(1), .PIPE_STAGES(2)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
        .A(A[0:0]), .B(B[0:0]), .out_valid(ovw),
        .A_greater_B(gw), .A_equal_B(ew), .A_lesser_B(lw)
    );

    // ---------------- reference model ----------------
    localparam int HistLen = 4096;
    logic       hist_r [HistLen];
    logic       hist_v [HistLen];
    logic [2:0] hist_c [HistLen];
    logic [2:0] exp_f  [2];
    int         depth  [2];
    int         cyc = 0;

    // Signed values by plain arithmetic: subtract 2^WIDTH when the MSB is set.
    function automatic logic [2:0] ref_cmp(input logic sm, input logic [3:0] a,
                                           input logic [3:0] b);
        int va = int'(a);
        int vb = int'(b);
        if (sm && a[3]) va = va - 16;
        if (sm && b[3]) vb = vb - 16;
        if (va > vb) return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    // A sample from cycle s is visible after edge s+P-1 unless a reset edge
    // landed anywhere from its sampling edge up to now.
    task automatic model_check(input int idx, input logic ov, input logic [2:0] fl);
        int   s  = cyc - depth[idx] + 1;
        logic ev = (s >= 0) ? hist_v[s] : 1'b0;
        for (int k = (s < 0 ? 0 : s); k <= cyc; k++) begin
            if (hist_r[k]) ev = 1'b0;
        end
        if (hist_r[cyc]) exp_f[idx] = 3'b000;
        else if (ev)     exp_f[idx] = hist_c[s];
        check(idx == 0 ? "p1_out_valid" : "p3_out_valid", ov, ev);
        check3(idx == 0 ? "p1_flags" : "p3_flags", fl, exp_f[idx]);
        if (ov === 1'b1) begin
            checks++;
            if ($countones(fl) != 1) begin
                failures++;
                $display("FAIL onehot_p%0d cycle=%0d got=%b want=one-hot", depth[idx], cyc, fl);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic sm,
                        input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rst = r; in_valid = v; signed_mode = sm; A = a; B = b;
        hist_r[cyc] = r;
        hist_v[cyc] = v;
        hist_c[cyc] = v ? ref_cmp(sm, a, b) : 3'b000;
        @(posedge clk);
        #1;
        model_check(0, ov1, {g1, e1, l1});
        model_check(1, ov3, {g3, e3, l3});
        cyc++;
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 1'bx, 4'bxxxx, 4'bxxxx);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       sm;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] want;   // {gt, eq, lt}
    } vec_t;

    vec_t tbl [10];

    initial begin
        depth[0] = 1;
        depth[1] = 3;
        exp_f[0] = 3'b000;
        exp_f[1] = 3'b000;

        tbl[0] = '{1'b0, 4'b1010, 4'b0110, 3'b100};
        tbl[1] = '{1'b0, 4'b0101, 4'b1100, 3'b001};
        tbl[2] = '{1'b0, 4'b1101, 4'b1101, 3'b010};
        tbl[3] = '{1'b0, 4'b0000, 4'b0000, 3'b010};
        tbl[4] = '{1'b0, 4'b1111, 4'b1111, 3'b010};
        tbl[5] = '{1'b1, 4'b1010, 4'b0110, 3'b001};
        tbl[6] = '{1'b1, 4'b1000, 4'b0111, 3'b001};
        tbl[7] = '{1'b0, 4'b1000, 4'b0111, 3'b100};
        tbl[8] = '{1'b1, 4'b0000, 4'b1111, 3'b100};
        tbl[9] = '{1'b1, 4'b1111, 4'b1111, 3'b010};

        rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0; A = '0; B = '0;

        // Reset, with a valid sample presented during reset that must vanish.
        step(1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        check("reset_p1_all_zero", |{ov1, g1, e1, l1}, 1'b0);
        check("reset_p3_all_zero", |{ov3, g3, e3, l3}, 1'b0);
        check("reset_w1_all_zero", |{ovw, gw, ew, lw}, 1'b0);
        bubble();
        bubble();
        check("reset_p3_no_pulse", ov3, 1'b0);

        // Table: each vector followed by two X-driven idle slots; P=1 shows it
        // right away and holds it, P=3 shows it after the second idle slot.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, tbl[i].sm, tbl[i].a, tbl[i].b);
            check3($sformatf("tbl%0d_p1", i), {g1, e1, l1}, tbl[i].want);
            bubble();
            bubble();
            check3($sformatf("tbl%0d_p1_hold", i), {g1, e1, l1}, tbl[i].want);
            check3($sformatf("tbl%0d_p3", i), {g3, e3, l3}, tbl[i].want);
            check($sformatf("tbl%0d_p3_valid", i), ov3, 1'b1);
        end

        // WIDTH=1 boundary: signed 1 (-1) < 0, unsigned 1 > 0 (P=2).
        step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000);
        bubble();
        check("w1_signed_valid", ovw, 1'b1);
        check3("w1_signed_lt", {gw, ew, lw}, 3'b001);
        step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000);
        bubble();
        check3("w1_unsigned_gt", {gw, ew, lw}, 3'b100);
        bubble();
        check("w1_idle_valid", ovw, 1'b0);
        check3("w1_idle_hold", {gw, ew, lw}, 3'b100);

        // Alternating valid pattern with X during gaps.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, i[0], 4'(i * 3), 4'(i * 5));
            bubble();
        end

        // Reset mid-stream with samples in flight.
        step(1'b0, 1'b1, 1'b0, 4'b1010, 4'b0110);
        step(1'b0, 1'b1, 1'b1, 4'b1010, 4'b0110);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
        check("midrst_p1_zero", |{ov1, g1, e1, l1}, 1'b0);
        check("midrst_p3_zero", |{ov3, g3, e3, l3}, 1'b0);
        bubble();
        bubble();
        bubble();
        check("midrst_p3_no_pulse", ov3, 1'b0);

        // Exhaustive pairs, both modes, full throughput.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    step(1'b0, 1'b1, m[0], 4'(a), 4'(b));
                end
            end
        end

        // Random traffic with random gaps and occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 4'($urandom), 4'($urandom));
        end
        bubble();
        bubble();
        bubble();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
